// File: rtl/clock_divider_multi.sv
// ============================================================================
// Module   : clock_divider_multi
// Purpose  : CHANNELS independent clock dividers (toggle/pulse) with global
//            halt and single-step, glitch-free runtime divisor reload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_multi #(
   parameter int               CHANNELS        = 2,
   parameter int               WIDTH           = 28,
   parameter logic [WIDTH-1:0] DEFAULT_DIVISOR = WIDTH'(1),
   parameter int               CH_BITS         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                input_clock,
   input  logic                reset_n,
   input  logic                halt,
   input  logic                step,
   input  logic [CHANNELS-1:0] channel_enable,
   input  logic                load_valid,
   input  logic [CH_BITS-1:0]  load_channel,
   input  logic [WIDTH-1:0]    load_divisor,
   input  logic                load_mode,
   output logic [CHANNELS-1:0] output_clock,
   output logic [CHANNELS-1:0] tick,
   output logic                running
);

   logic w_go;
   assign w_go = !halt || step;

   always_ff @(posedge input_clock) begin
      if (!reset_n) begin
         running <= 1'b0;
      end else begin
         running <= !halt && (|channel_enable);
      end
   end

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
         logic [WIDTH-1:0] r_cnt;
         logic [WIDTH-1:0] r_div;
         logic [WIDTH-1:0] r_sdiv;
         logic             r_mode;
         logic             r_smode;
         logic             r_out;
         logic             r_tick;
         logic             w_hit;
         logic             w_adv;
         logic             w_term;
         logic             w_nmode;
         logic [WIDTH-1:0] w_ndiv;
         logic [WIDTH-1:0] w_last;

         // Out-of-range channel indices never match, so such writes are dropped.
         assign w_hit   = load_valid && (load_channel == CH_BITS'(i));
         assign w_ndiv  = w_hit ? load_divisor : r_sdiv;
         assign w_nmode = w_hit ? load_mode    : r_smode;
         assign w_adv   = channel_enable[i] && w_go;
         assign w_last  = (r_div == '0) ? '0 : r_div - 1'b1;
         assign w_term  = w_adv && (r_cnt == w_last);

         always_ff @(posedge input_clock) begin
            if (!reset_n) begin
               r_cnt   <= '0;
               r_div   <= DEFAULT_DIVISOR;
               r_sdiv  <= DEFAULT_DIVISOR;
               r_mode  <= 1'b0;
               r_smode <= 1'b0;
               r_out   <= 1'b0;
               r_tick  <= 1'b0;
            end else begin
               r_sdiv  <= w_ndiv;
               r_smode <= w_nmode;
               if (!channel_enable[i]) begin
                  r_cnt  <= '0;
                  r_out  <= 1'b0;
                  r_tick <= 1'b0;
                  r_div  <= w_ndiv;
                  r_mode <= w_nmode;
               end else if (w_term) begin
                  // Shadow settings take effect here, including a same-edge load.
                  r_cnt  <= '0;
                  r_tick <= 1'b1;
                  r_div  <= w_ndiv;
                  r_mode <= w_nmode;
                  if (w_nmode && !r_mode) begin
                     r_out <= 1'b0;
                  end else if (w_nmode) begin
                     r_out <= 1'b1;
                  end else begin
                     r_out <= ~r_out;
                  end
               end else if (w_adv) begin
                  r_cnt  <= r_cnt + 1'b1;
                  r_tick <= 1'b0;
                  if (r_mode) begin
                     r_out <= 1'b0;
                  end
               end else begin
                  r_tick <= 1'b0;
               end
            end
         end

         assign output_clock[i] = r_out;
         assign tick[i]         = r_tick;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
// ============================================================================
// Module   : tb_clock_divider_multi
// Purpose  : Randomized and directed bench for clock_divider_multi against a
//            countdown-style reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_divider_multi;

   localparam int NCH = 3;
   localparam int W   = 8;
   localparam int CB  = 2;
   localparam int DEF = 3;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           halt;
   logic           step;
   logic [NCH-1:0] channel_enable;
   logic           load_valid;
   logic [CB-1:0]  load_channel;
   logic [W-1:0]   load_divisor;
   logic           load_mode;
   logic [NCH-1:0] output_clock;
   logic [NCH-1:0] tick;
   logic           running;

   int n_vec = 0;
   int n_mis = 0;

   // Reference state: remaining advances until next terminal count.
   int rem   [NCH];
   int adiv  [NCH];
   int sdiv  [NCH];
   bit amode [NCH];
   bit smode [NCH];
   bit oc    [NCH];
   bit tk    [NCH];
   bit run_m;

   clock_divider_multi #(
      .CHANNELS        (NCH),
      .WIDTH           (W),
      .DEFAULT_DIVISOR (W'(DEF))
   ) dut (
      .input_clock    (clk),
      .reset_n        (reset_n),
      .halt           (halt),
      .step           (step),
      .channel_enable (channel_enable),
      .load_valid     (load_valid),
      .load_channel   (load_channel),
      .load_divisor   (load_divisor),
      .load_mode      (load_mode),
      .output_clock   (output_clock),
      .tick           (tick),
      .running        (running)
   );

   always #5 clk = ~clk;

   function automatic int eff(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_update();
      if (!reset_n) begin
         for (int c = 0; c < NCH; c++) begin
            adiv[c] = DEF; sdiv[c] = DEF; rem[c] = eff(DEF);
            amode[c] = 0;  smode[c] = 0;  oc[c] = 0; tk[c] = 0;
         end
         run_m = 0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            bit hit;
            int nd;
            bit nm;
            hit = load_valid && (int'(load_channel) == c);
            nd  = hit ? int'(load_divisor) : sdiv[c];
            nm  = hit ? load_mode : smode[c];
            if (!channel_enable[c]) begin
               adiv[c] = nd; amode[c] = nm; rem[c] = eff(nd);
               oc[c] = 0; tk[c] = 0;
            end else if (!halt || step) begin
               rem[c]--;
               if (rem[c] == 0) begin
                  tk[c] = 1;
                  if (nm && !amode[c]) oc[c] = 0;
                  else if (nm)         oc[c] = 1;
                  else                 oc[c] = !oc[c];
                  adiv[c] = nd; amode[c] = nm; rem[c] = eff(nd);
               end else begin
                  tk[c] = 0;
                  if (amode[c]) oc[c] = 0;
               end
            end else begin
               tk[c] = 0;
            end
            sdiv[c] = nd; smode[c] = nm;
         end
         run_m = !halt && (|channel_enable);
      end
   endtask

   task automatic cycle();
      logic [NCH-1:0] e_oc;
      logic [NCH-1:0] e_tk;
      @(posedge clk);
      model_update();
      #1;
      for (int c = 0; c < NCH; c++) begin
         e_oc[c] = oc[c];
         e_tk[c] = tk[c];
      end
      check_value("output_clock", 32'(output_clock), 32'(e_oc));
      check_value("tick",         32'(tick),         32'(e_tk));
      check_value("running",      32'(running),      32'(run_m));
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic load(input int ch, input int d, input bit m);
      load_valid = 1; load_channel = CB'(ch); load_divisor = W'(d); load_mode = m;
      cycle();
      load_valid = 0;
   endtask

   initial begin
      reset_n = 0; halt = 0; step = 0; channel_enable = '0;
      load_valid = 0; load_channel = '0; load_divisor = '0; load_mode = 0;
      cycles(2);
      reset_n = 1;
      channel_enable = 3'b001;
      cycles(20);

      load(1, 4, 1'b1);
      channel_enable = 3'b011;
      cycles(16);

      for (int k = 0; k < 10 && rem[0] != 2; k++) cycle();
      check_value("ch0_cnt_is_1", 32'(rem[0]), 32'd2);
      load(0, 5, 1'b0);
      cycles(25);

      halt = 1;
      for (int k = 0; k < 10; k++) begin
         step = (k == 3 || k == 7);
         cycle();
      end
      step = 0; halt = 0;
      cycles(10);

      load(0, 0, 1'b0);
      load(1, 1, 1'b0);
      cycles(6);
      load(3, 7, 1'b1);
      channel_enable = 3'b111;
      cycles(12);

      reset_n = 0; load_valid = 1; load_channel = 0; load_divisor = 9; load_mode = 1;
      cycle();
      reset_n = 1; load_valid = 0;
      cycles(10);

      for (int k = 0; k < 3000; k++) begin
         reset_n    = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 19) == 0) halt = ~halt;
         step       = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 24) == 0) channel_enable = NCH'($urandom);
         load_valid   = ($urandom_range(0, 5) == 0);
         load_channel = CB'($urandom_range(0, 3));
         load_divisor = W'($urandom_range(0, 6));
         load_mode    = 1'($urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
